// File: rtl/mem_copy_dma_pkg.sv
// Shared types and constants for the memory-to-memory copy engine.
//   state_e : copy FSM states
//   MEM_AW  : default active word-address width of the attached memory
package mem_copy_dma_pkg;

    localparam int MEM_AW = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_copy_dma.sv
// Single-port memory copy engine. Reads one word and writes one word per
// pair of cycles, copying len words from src_addr to dst_addr inside the
// same word-addressed memory. Overlapping forward copies run top-down.
//   clock, reset      : clock, asynchronous active-low reset
//   start             : copy request, sampled in IDLE only
//   src_addr/dst_addr : first source/destination word address
//   len               : word count 0..2^AW
//   busy, done        : status (done is a one-cycle pulse)
//   mem_ren/mem_wen   : memory read/write enables (never both set)
//   mem_addr/mem_din  : memory address and write data
//   mem_dout          : combinational memory read data
module mem_copy_dma
    import mem_copy_dma_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = MEM_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [N-1:0]  mem_addr,
    output logic [N-1:0]  mem_din,
    input  logic [N-1:0]  mem_dout
);

    localparam logic [AW-1:0] A_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   C_ONE = {{AW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic          desc_q, desc_d;

    // Outputs are registered, decoded from the next state so they line up
    // with the state they describe.
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic [N-1:0]  addr_q, addr_d;
    logic [N-1:0]  din_q, din_d;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        desc_d  = desc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    desc_d = dst_addr > src_addr;
                    cnt_d  = len;
                    // A forward overlap must copy from the top down. Using only
                    // the low AW bits of len keeps len=2^AW correct modulo 2^AW.
                    if (dst_addr > src_addr) begin
                        src_d = src_addr + len[AW-1:0] - A_ONE;
                        dst_d = dst_addr + len[AW-1:0] - A_ONE;
                    end else begin
                        src_d = src_addr;
                        dst_d = dst_addr;
                    end
                    state_d = (len != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                data_d  = mem_dout;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                src_d   = desc_q ? src_q - A_ONE : src_q + A_ONE;
                dst_d   = desc_q ? dst_q - A_ONE : dst_q + A_ONE;
                cnt_d   = cnt_q - C_ONE;
                state_d = (cnt_q == C_ONE) ? S_DONE : S_READ;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = state_d != S_IDLE;
        done_d = state_d == S_DONE;
        ren_d  = state_d == S_READ;
        wen_d  = state_d == S_WRITE;
        addr_d = '0;
        din_d  = '0;
        if (state_d == S_READ) begin
            addr_d = {{(N-AW){1'b0}}, src_d};
        end else if (state_d == S_WRITE) begin
            addr_d = {{(N-AW){1'b0}}, dst_d};
            din_d  = data_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            desc_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            desc_q  <= desc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mem_ren  = ren_q;
    assign mem_wen  = wen_q;
    assign mem_addr = addr_q;
    assign mem_din  = din_q;

endmodule
